udma_rx_ch_ctrl: RTL and testbench
==================================

Name: udma_rx_ch_ctrl

Overview:
- uDMA RX channel controller: the channel-side counterpart of the peripheral cfg_rx_* interface.
- Consumes the peripheral's start address, size, continuous, enable and clear controls; returns channel enable, pending, current address and bytes left.
- Accepts the peripheral RX data stream and issues byte-lane-aligned 32-bit L2 write requests with a req/gnt handshake.
- Sits between any uDMA peripheral (e.g. UART RX) and the L2 interconnect, on the system clock.

Parameters:
L2_AWIDTH_NOAL, 12, L2 byte-address width
TRANS_SIZE, 16, transfer size / bytes-left counter width

Ports:
clk_i  in  1  system clock
rstn_i  in  1  reset; one clock, reset asynchronous active-low
cfg_startaddr_i  in  L2_AWIDTH_NOAL  transfer start byte address
cfg_size_i  in  TRANS_SIZE  transfer size in bytes
cfg_continuous_i  in  1  auto-reload at end of transfer
cfg_en_i  in  1  single-cycle start/queue pulse
cfg_clr_i  in  1  single-cycle abort pulse
cfg_en_o  out  1  channel running
cfg_pending_o  out  1  queued transfer held
cfg_curr_addr_o  out  L2_AWIDTH_NOAL  next write address
cfg_bytes_left_o  out  TRANS_SIZE  bytes not yet accepted
data_i  in  32  stream data, LSB-aligned
data_datasize_i  in  2  0=byte, 1=half, 2/3=word
data_valid_i  in  1  stream valid
data_ready_o  out  1  stream ready
l2_req_o  out  1  L2 write request
l2_gnt_i  in  1  L2 grant
l2_addr_o  out  L2_AWIDTH_NOAL  write byte address
l2_wdata_o  out  32  lane-replicated data
l2_be_o  out  4  byte enables
eot_o  out  1  end-of-transfer pulse

Behaviour:
- Reset: all outputs 0; state IDLE; shadow registers 0.
- States: IDLE, RUN, DRAIN.
- IDLE + cfg_en_i with cfg_size_i != 0:
  - load curr_addr = cfg_startaddr_i, bytes_left = cfg_size_i; go to RUN; cfg_en_o = 1 next cycle.
  - cfg_size_i == 0: ignored, no eot.
- RUN/DRAIN + cfg_en_i:
  - if pending_o = 0: capture startaddr/size into shadow; pending_o = 1.
  - if pending_o = 1: ignored; shadow unchanged.
- Step = 1/2/4 for datasize 0/1/(2,3).
- Beat accepted when data_valid_i & data_ready_o:
  - beat loads the request register; l2_req_o = 1 from the next cycle.
  - same edge: curr_addr += step (wraps modulo 2^L2_AWIDTH_NOAL).
  - same edge: bytes_left = (bytes_left <= step) ? 0 : bytes_left - step.
- Last beat (bytes_left <= step at acceptance): go to DRAIN; data_ready_o = 0 in DRAIN.
- l2_req_o, l2_addr_o, l2_wdata_o and l2_be_o stay stable until l2_gnt_i.
- Byte enables: byte: 4'b0001 << addr[1:0]; half: 4'b0011 << {addr[1],1'b0}; word: 4'b1111. Misaligned half/word is a software error; lanes as stated.
- Write data: byte {4{d[7:0]}}; half {2{d[15:0]}}; word d.
- DRAIN + grant of last beat: eot_o = 1 for one cycle, then:
  - pending_o = 1: load shadow, clear pending, go to RUN.
  - else cfg_continuous_i = 1: reload from live cfg_startaddr_i/cfg_size_i, go to RUN.
  - else: go to IDLE, cfg_en_o = 0.
- cfg_en_i on the same cycle as the DRAIN grant: the pending check uses the pre-edge pending_o.
- data_ready_o (base build) = (state == RUN) & (~l2_req_o | l2_gnt_i): back-to-back beats at 1 per cycle.
- cfg_clr_i (highest priority, any state), next cycle:
  - state IDLE; l2_req_o = 0 (in-flight request dropped); pending_o = 0; cfg_en_o = 0; bytes_left = 0; curr_addr = 0.
  - no eot_o; cfg_en_i on the same cycle is ignored.
- Reset mid-transfer: immediate return to reset values.

Optional Feature:
- Macro UDMA_RX_CH_SKID_EN.
- Defined: one-entry skid buffer in front of the request register. data_ready_o = (state == RUN) & ~skid_full, with no combinational path from l2_gnt_i. Throughput stays 1 beat/cycle under continuous grant. A beat accepted into the skid counts as accepted for counters. DRAIN waits until both skid and request are empty and granted. cfg_clr_i also flushes the skid.
- Undefined: no skid; data_ready_o as in base behaviour.

Test Plan:
- Start addr 0x100, size 8, byte beats 0x11..0x88, gnt always 1 -> addrs 0x100..0x107; be 1,2,4,8,1,2,4,8; eot 1 cycle after 8th grant; en_o = 0; bytes_left = 0.
- Addr 0x202, size 6, half beats 0xAABB, 0xCCDD, 0xEEFF -> be 4'b1100, 4'b0011, 4'b1100; wdata 0xAABBAABB etc.; curr_addr ends 0x208.
- Size 4 running; second cfg_en_i with addr 0x300, size 4 -> pending_o = 1; third cfg_en_i ignored; after eot, addr 0x300 loaded, pending_o = 0; second eot ends in IDLE.
- Continuous = 1, size 4 word beats -> eot every beat; curr_addr reloads to start; en_o stays 1.
- gnt_i held 0 for 5 cycles with req pending -> addr/data/be stable; base build: ready_o = 0; skid build: exactly one extra beat accepted.
- cfg_clr_i mid-transfer with req_o = 1 -> next cycle req_o = 0, en_o = 0, pending_o = 0, bytes_left = 0, no eot.

Source files
------------

// File: rtl/udma_rx_ch_ctrl.sv
// uDMA RX channel controller: peripheral stream beats -> byte-lane L2 writes.
// Build option UDMA_RX_CH_SKID_EN adds a one-entry skid ahead of the request.
module udma_rx_ch_ctrl #(
   parameter int L2_AWIDTH_NOAL = 12,
   parameter int TRANS_SIZE     = 16
) (
   input  logic                      clk_i,
   input  logic                      rstn_i,
   input  logic [L2_AWIDTH_NOAL-1:0] cfg_startaddr_i,
   input  logic [TRANS_SIZE-1:0]     cfg_size_i,
   input  logic                      cfg_continuous_i,
   input  logic                      cfg_en_i,
   input  logic                      cfg_clr_i,
   output logic                      cfg_en_o,
   output logic                      cfg_pending_o,
   output logic [L2_AWIDTH_NOAL-1:0] cfg_curr_addr_o,
   output logic [TRANS_SIZE-1:0]     cfg_bytes_left_o,
   input  logic [31:0]               data_i,
   input  logic [1:0]                data_datasize_i,
   input  logic                      data_valid_i,
   output logic                      data_ready_o,
   output logic                      l2_req_o,
   input  logic                      l2_gnt_i,
   output logic [L2_AWIDTH_NOAL-1:0] l2_addr_o,
   output logic [31:0]               l2_wdata_o,
   output logic [3:0]                l2_be_o,
   output logic                      eot_o
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

   state_e                    r_state;
   state_e                    w_state_nxt;
   logic                      r_pending;
   logic [L2_AWIDTH_NOAL-1:0] r_sh_addr;
   logic [TRANS_SIZE-1:0]     r_sh_size;
   logic [L2_AWIDTH_NOAL-1:0] r_curr_addr;
   logic [TRANS_SIZE-1:0]     r_bytes_left;
   logic                      r_req;
   logic [L2_AWIDTH_NOAL-1:0] r_addr;
   logic [31:0]               r_wdata;
   logic [3:0]                r_be;
   logic                      r_eot;

   logic                      w_ld_cfg;
   logic                      w_ld_sh;
   logic                      w_capture;
   logic                      w_accept;
   logic                      w_last;
   logic                      w_done;
   logic                      w_ready;
   logic                      w_req_free;
   logic                      w_sk_full;
   logic [2:0]                w_step;
   logic [3:0]                w_be;
   logic [31:0]               w_wdata;

   always_comb begin
      w_step  = 3'd4;
      w_be    = 4'b1111;
      w_wdata = data_i;
      case (data_datasize_i)
         2'd0: begin
            w_step  = 3'd1;
            w_be    = 4'b0001 << r_curr_addr[1:0];
            w_wdata = {4{data_i[7:0]}};
         end
         2'd1: begin
            w_step  = 3'd2;
            w_be    = 4'b0011 << {r_curr_addr[1], 1'b0};
            w_wdata = {2{data_i[15:0]}};
         end
         default: ;
      endcase
   end

   assign w_last     = r_bytes_left <= TRANS_SIZE'(w_step);
   assign w_req_free = ~r_req | l2_gnt_i;
   assign w_accept   = data_valid_i & w_ready;
   // Final grant: nothing may still sit in the skid behind it
   assign w_done     = (r_state == DRAIN) & r_req & l2_gnt_i & ~w_sk_full;

   always_comb begin
      w_state_nxt = r_state;
      w_ld_cfg    = 1'b0;
      w_ld_sh     = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_pending) begin
               w_ld_sh     = 1'b1;
               w_state_nxt = RUN;
            end else if (cfg_en_i && (cfg_size_i != '0)) begin
               w_ld_cfg    = 1'b1;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            if (w_accept && w_last)
               w_state_nxt = DRAIN;
         end
         DRAIN: begin
            if (w_done) begin
               if (r_pending) begin
                  w_ld_sh     = 1'b1;
                  w_state_nxt = RUN;
               end else if (cfg_continuous_i) begin
                  w_ld_cfg    = 1'b1;
                  w_state_nxt = RUN;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      w_capture = (r_state != IDLE) & cfg_en_i & ~r_pending;
      if (cfg_clr_i) begin
         w_state_nxt = IDLE;
         w_ld_cfg    = 1'b0;
         w_ld_sh     = 1'b0;
         w_capture   = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state      <= IDLE;
         r_pending    <= 1'b0;
         r_sh_addr    <= '0;
         r_sh_size    <= '0;
         r_curr_addr  <= '0;
         r_bytes_left <= '0;
         r_eot        <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_eot   <= w_done & ~cfg_clr_i;
         if (cfg_clr_i) begin
            r_pending <= 1'b0;
         end else if (w_capture) begin
            r_pending <= 1'b1;
            r_sh_addr <= cfg_startaddr_i;
            r_sh_size <= cfg_size_i;
         end else if (w_ld_sh) begin
            r_pending <= 1'b0;
         end
         if (cfg_clr_i) begin
            r_curr_addr  <= '0;
            r_bytes_left <= '0;
         end else if (w_ld_cfg) begin
            r_curr_addr  <= cfg_startaddr_i;
            r_bytes_left <= cfg_size_i;
         end else if (w_ld_sh) begin
            r_curr_addr  <= r_sh_addr;
            r_bytes_left <= r_sh_size;
         end else if (w_accept) begin
            r_curr_addr  <= r_curr_addr + L2_AWIDTH_NOAL'(w_step);
            r_bytes_left <= w_last ? '0 :
                            r_bytes_left - TRANS_SIZE'(w_step);
         end
      end
   end

`ifdef UDMA_RX_CH_SKID_EN
   logic                      r_sk_full;
   logic [L2_AWIDTH_NOAL-1:0] r_sk_addr;
   logic [31:0]               r_sk_wdata;
   logic [3:0]                r_sk_be;

   assign w_sk_full = r_sk_full;
   assign w_ready   = (r_state == RUN) & ~r_sk_full;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_req      <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_be       <= '0;
         r_sk_full  <= 1'b0;
         r_sk_addr  <= '0;
         r_sk_wdata <= '0;
         r_sk_be    <= '0;
      end else if (cfg_clr_i) begin
         r_req     <= 1'b0;
         r_sk_full <= 1'b0;
      end else if (w_req_free) begin
         if (r_sk_full) begin
            r_req     <= 1'b1;
            r_addr    <= r_sk_addr;
            r_wdata   <= r_sk_wdata;
            r_be      <= r_sk_be;
            r_sk_full <= 1'b0;
         end else if (w_accept) begin
            r_req   <= 1'b1;
            r_addr  <= r_curr_addr;
            r_wdata <= w_wdata;
            r_be    <= w_be;
         end else begin
            r_req <= 1'b0;
         end
      end else if (w_accept) begin
         r_sk_full  <= 1'b1;
         r_sk_addr  <= r_curr_addr;
         r_sk_wdata <= w_wdata;
         r_sk_be    <= w_be;
      end
   end
`else
   assign w_sk_full = 1'b0;
   assign w_ready   = (r_state == RUN) & w_req_free;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_req   <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_be    <= '0;
      end else if (cfg_clr_i) begin
         r_req <= 1'b0;
      end else if (w_accept) begin
         r_req   <= 1'b1;
         r_addr  <= r_curr_addr;
         r_wdata <= w_wdata;
         r_be    <= w_be;
      end else if (l2_gnt_i) begin
         r_req <= 1'b0;
      end
   end
`endif

   assign cfg_en_o         = (r_state != IDLE);
   assign cfg_pending_o    = r_pending;
   assign cfg_curr_addr_o  = r_curr_addr;
   assign cfg_bytes_left_o = r_bytes_left;
   assign data_ready_o     = w_ready;
   assign l2_req_o         = r_req;
   assign l2_addr_o        = r_addr;
   assign l2_wdata_o       = r_wdata;
   assign l2_be_o          = r_be;
   assign eot_o            = r_eot;

endmodule

// File: tb/tb_udma_rx_ch_ctrl.sv
// Scoreboard bench for udma_rx_ch_ctrl: transfer-level model predicts L2 writes and eot.
`timescale 1ns/1ps
module tb_udma_rx_ch_ctrl;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [11:0] cfg_startaddr = '0;
   logic [15:0] cfg_size = '0;
   logic        cfg_continuous = 1'b0;
   logic        cfg_en = 1'b0;
   logic        cfg_clr = 1'b0;
   logic        cfg_en_o;
   logic        cfg_pending_o;
   logic [11:0] cfg_curr_addr_o;
   logic [15:0] cfg_bytes_left_o;
   logic [31:0] data = '0;
   logic [1:0]  dsz = '0;
   logic        data_valid = 1'b0;
   logic        data_ready_o;
   logic        l2_req_o;
   logic        l2_gnt = 1'b0;
   logic [11:0] l2_addr_o;
   logic [31:0] l2_wdata_o;
   logic [3:0]  l2_be_o;
   logic        eot_o;

   udma_rx_ch_ctrl #(.L2_AWIDTH_NOAL(12), .TRANS_SIZE(16)) dut (
      .clk_i(clk), .rstn_i(rstn),
      .cfg_startaddr_i(cfg_startaddr), .cfg_size_i(cfg_size),
      .cfg_continuous_i(cfg_continuous), .cfg_en_i(cfg_en),
      .cfg_clr_i(cfg_clr), .cfg_en_o(cfg_en_o),
      .cfg_pending_o(cfg_pending_o), .cfg_curr_addr_o(cfg_curr_addr_o),
      .cfg_bytes_left_o(cfg_bytes_left_o),
      .data_i(data), .data_datasize_i(dsz), .data_valid_i(data_valid),
      .data_ready_o(data_ready_o),
      .l2_req_o(l2_req_o), .l2_gnt_i(l2_gnt), .l2_addr_o(l2_addr_o),
      .l2_wdata_o(l2_wdata_o), .l2_be_o(l2_be_o), .eot_o(eot_o)
   );

   typedef struct {
      logic [11:0] a;
      logic [31:0] d;
      logic [3:0]  be;
   } wr_t;
   typedef struct {
      logic [11:0] a;
      int          s;
   } xf_t;

   wr_t         sb[$];
   xf_t         xq[$];
   int          n_tests = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          last_gnt = -10;
   int          eot_cnt = 0;
   int          exp_eot = 0;
   int          gnt_mode = 1;
   logic [11:0] m_addr = '0;
   int          m_left = 0;
   bit          m_act = 0;
   bit          m_cont = 0;
   logic [11:0] c_a = '0;
   int          c_s = 0;

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial forever begin
      @(posedge clk);
      #1;
      case (gnt_mode)
         0:       l2_gnt = 1'b0;
         1:       l2_gnt = 1'b1;
         default: l2_gnt = 1'($urandom_range(0, 1));
      endcase
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic timeout(input string nm);
      n_tests++;
      n_fail++;
      $display("FAIL %s: wait bound expired (t=%0t)", nm, $time);
   endtask

   // Transfer-level reference model
   function automatic void m_begin(input logic [11:0] a, input int s);
      m_addr = a;
      m_left = s;
      m_act  = 1;
   endfunction

   function automatic void m_cfg_en(input logic [11:0] a, input int s);
      xf_t x;
      if (!m_act) begin
         if (s != 0) m_begin(a, s);
      end else if (xq.size() == 0) begin
         x.a = a;
         x.s = s;
         xq.push_back(x);
      end
   endfunction

   function automatic void m_accept(input logic [1:0] sz, input logic [31:0] d);
      int  step;
      int  base;
      wr_t w;
      xf_t x;
      step = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      base = (step == 4) ? 0 : ((int'(m_addr) % 4) / step) * step;
      w.a = m_addr;
      for (int l = 0; l < 4; l++) begin
         w.be[l]        = (l >= base) && (l < base + step);
         w.d[8*l +: 8]  = d[8*(l % step) +: 8];
      end
      sb.push_back(w);
      m_addr = 12'((int'(m_addr) + step) % 4096);
      if (m_left <= step) begin
         m_left = 0;
         exp_eot++;
         if (xq.size() != 0) begin
            x = xq.pop_front();
            m_begin(x.a, x.s);
         end else if (m_cont) begin
            m_begin(c_a, c_s);
         end else begin
            m_act = 0;
         end
      end else begin
         m_left = m_left - step;
      end
   endfunction

   initial begin : monitor
      wr_t e;
      forever begin
         @(negedge clk);
         if (rstn) begin
            if (eot_o) begin
               eot_cnt++;
               chk("eot_timing", cyc, last_gnt + 1);
            end
            if (l2_req_o && l2_gnt) begin
               if (sb.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL l2_unexpected: addr %0h with empty scoreboard", l2_addr_o);
               end else begin
                  e = sb.pop_front();
                  chk("l2_addr", l2_addr_o, e.a);
                  chk("l2_wdata", l2_wdata_o, e.d);
                  chk("l2_be", l2_be_o, e.be);
               end
               last_gnt = cyc;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_pulse(input logic [11:0] a, input int s);
      cfg_startaddr = a;
      cfg_size      = 16'(s);
      cfg_en        = 1'b1;
      m_cfg_en(a, s);
      tick();
      cfg_en = 1'b0;
   endtask

   task automatic beat_try(input bit v, input logic [1:0] sz,
                           input logic [31:0] d, output bit acc);
      data_valid = v;
      data       = d;
      dsz        = sz;
      @(negedge clk);
      acc = v && data_ready_o;
      if (acc) m_accept(sz, d);
      tick();
      data_valid = 1'b0;
   endtask

   task automatic send_beat(input logic [1:0] sz, input logic [31:0] d,
                            input int bubble);
      bit acc;
      int n;
      acc = 0;
      n   = 0;
      while (!acc && n < 100) begin
         beat_try($urandom_range(0, 99) >= bubble, sz, d, acc);
         n++;
      end
      if (!acc) timeout("beat_accept");
   endtask

   task automatic finish_xfer(input int bubble, input bit rnd_sz);
      int n;
      n = 0;
      while (m_act && n < 64) begin
         send_beat(rnd_sz ? 2'($urandom_range(0, 3)) : 2'd0, $urandom, bubble);
         n++;
      end
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while ((sb.size() != 0 || eot_cnt != exp_eot) && n < 300) begin
         tick();
         n++;
      end
      if (n >= 300) timeout("drain");
   endtask

   initial begin : main
      int n_acc;
      int e0;
      logic [31:0] d;
      bit exp_skid;
`ifdef UDMA_RX_CH_SKID_EN
      exp_skid = 1;
`else
      exp_skid = 0;
`endif
      repeat (3) tick();
      chk("rst_en", cfg_en_o, 0);
      chk("rst_pending", cfg_pending_o, 0);
      chk("rst_curr", cfg_curr_addr_o, 0);
      chk("rst_left", cfg_bytes_left_o, 0);
      chk("rst_req", l2_req_o, 0);
      chk("rst_eot", eot_o, 0);
      chk("rst_ready", data_ready_o, 0);
      rstn = 1'b1;
      tick();

      // byte beats, continuous grant
      gnt_mode = 1;
      cfg_pulse(12'h100, 8);
      for (int i = 1; i <= 8; i++) send_beat(2'd0, 32'(8'h11 * i), 0);
      wait_done();
      chk("t1_eot", eot_cnt, 1);
      chk("t1_en", cfg_en_o, 0);
      chk("t1_left", cfg_bytes_left_o, 0);

      // half beats, lane replication
      cfg_pulse(12'h202, 6);
      send_beat(2'd1, 32'h0000AABB, 0);
      send_beat(2'd1, 32'h0000CCDD, 0);
      send_beat(2'd1, 32'h0000EEFF, 0);
      wait_done();
      chk("t2_curr", cfg_curr_addr_o, 12'h208);
      chk("t2_en", cfg_en_o, 0);

      // zero-size start is ignored
      cfg_pulse(12'h080, 0);
      tick();
      chk("sz0_en", cfg_en_o, 0);
      chk("sz0_eot", eot_cnt, exp_eot);

      // queued transfer
      gnt_mode = 2;
      e0 = exp_eot;
      cfg_pulse(12'h010, 4);
      cfg_pulse(12'h300, 4);
      chk("pend_set", cfg_pending_o, xq.size() != 0);
      cfg_pulse(12'h400, 4);
      chk("pend_hold", cfg_pending_o, xq.size() != 0);
      chk("pend_left", cfg_bytes_left_o, m_left);
      finish_xfer(20, 0);
      finish_xfer(20, 0);
      wait_done();
      chk("pend_eots", exp_eot, e0 + 2);
      chk("pend_clr", cfg_pending_o, 0);
      chk("pend_en", cfg_en_o, 0);

      // continuous reload
      gnt_mode = 1;
      cfg_continuous = 1'b1;
      m_cont = 1;
      c_a = 12'h040;
      c_s = 4;
      cfg_pulse(12'h040, 4);
      for (int k = 0; k < 2; k++) begin
         send_beat(2'd2, $urandom, 0);
         wait_done();
         chk("cont_en", cfg_en_o, 1);
         chk("cont_curr", cfg_curr_addr_o, c_a);
         chk("cont_left", cfg_bytes_left_o, c_s);
      end
      cfg_continuous = 1'b0;
      m_cont = 0;
      send_beat(2'd3, $urandom, 0);
      wait_done();
      chk("cont_stop_en", cfg_en_o, 0);

      // grant stall
      gnt_mode = 0;
      tick();
      tick();
      cfg_pulse(12'h500, 8);
      send_beat(2'd0, 32'hA1, 0);
      n_acc = 0;
      for (int i = 0; i < 5; i++) begin
         d = 32'hB0 + 32'(i);
         data_valid = 1'b1;
         data = d;
         dsz = 2'd0;
         @(negedge clk);
         chk("stall_req", l2_req_o, 1);
         chk("stall_addr", l2_addr_o, sb[0].a);
         chk("stall_wdata", l2_wdata_o, sb[0].d);
         chk("stall_be", l2_be_o, sb[0].be);
         if (data_ready_o) begin
            n_acc++;
            m_accept(2'd0, d);
         end
         tick();
      end
      data_valid = 1'b0;
      chk("stall_extra", n_acc, exp_skid ? 1 : 0);
      chk("stall_left", cfg_bytes_left_o, m_left);
      gnt_mode = 1;
      finish_xfer(0, 0);
      wait_done();
      chk("stall_en", cfg_en_o, 0);

      // abort with request in flight
      gnt_mode = 0;
      tick();
      tick();
      e0 = eot_cnt;
      cfg_pulse(12'h600, 8);
      cfg_pulse(12'h700, 4);
      send_beat(2'd0, 32'h5A, 0);
      chk("clr_pre_req", l2_req_o, 1);
      chk("clr_pre_pend", cfg_pending_o, 1);
      cfg_clr = 1'b1;
      cfg_en = 1'b1;
      cfg_startaddr = 12'h123;
      cfg_size = 16'd4;
      tick();
      cfg_clr = 1'b0;
      cfg_en = 1'b0;
      sb.delete();
      xq.delete();
      m_act = 0;
      m_left = 0;
      chk("clr_req", l2_req_o, 0);
      chk("clr_en", cfg_en_o, 0);
      chk("clr_pend", cfg_pending_o, 0);
      chk("clr_left", cfg_bytes_left_o, 0);
      chk("clr_curr", cfg_curr_addr_o, 0);
      gnt_mode = 1;
      repeat (4) tick();
      chk("clr_no_eot", eot_cnt, e0);
      chk("clr_idle", cfg_en_o, 0);

      // random transfers, first one wraps the address space
      gnt_mode = 2;
      for (int t = 0; t < 6; t++) begin
         cfg_pulse((t == 0) ? 12'hFFE : 12'($urandom), $urandom_range(1, 12));
         finish_xfer(30, 1);
         wait_done();
         chk("rnd_en", cfg_en_o, 0);
         chk("rnd_curr", cfg_curr_addr_o, m_addr);
      end

      // reset mid-transfer
      gnt_mode = 0;
      tick();
      tick();
      cfg_pulse(12'h050, 8);
      send_beat(2'd0, 32'h77, 0);
      rstn = 1'b0;
      #2;
      chk("arst_req", l2_req_o, 0);
      chk("arst_en", cfg_en_o, 0);
      chk("arst_left", cfg_bytes_left_o, 0);
      sb.delete();
      m_act = 0;
      m_left = 0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
